// File: rtl/adder_pipe_arbiter.sv
// Round-robin front end that shares one fixed-latency pipelined adder between N requesters.
// It tags each issued operand pair with its requester index and returns the sum to that requester.
module adder_pipe_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int LATENCY = 3,
  parameter int IDW     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic [N-1:0]     req_ready,
  input  logic             pause,
  output logic             add_valid,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  input  logic [W-1:0]     add_sum,
  output logic             rsp_valid,
  output logic [IDW-1:0]   rsp_id,
  output logic [W-1:0]     rsp_sum,
  output logic             busy
);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_tag;
  logic           r_add_valid;
  logic [W-1:0]   r_add_a;
  logic [W-1:0]   r_add_b;
  logic [LATENCY-1:0] r_tv;
  logic [IDW-1:0] r_tid [LATENCY];
  logic           r_rsp_valid;
  logic [IDW-1:0] r_rsp_id;
  logic [W-1:0]   r_rsp_sum;
  logic           r_busy;

  logic [N-1:0]   w_grant;
  logic [IDW-1:0] w_gnt_idx;
  logic           w_hit;
  int unsigned    w_idx;

  // Search starts at r_ptr and wraps; the first valid requester wins.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_hit     = 1'b0;
    w_idx     = '0;
    if (!pause) begin
      for (int unsigned i = 0; i < N; i++) begin
        w_idx = {{(32-IDW){1'b0}}, r_ptr} + i;
        if (w_idx >= 32'(N)) w_idx = w_idx - 32'(N);
        if (!w_hit && req_valid[w_idx]) begin
          w_hit            = 1'b1;
          w_grant[w_idx]   = 1'b1;
          w_gnt_idx        = w_idx[IDW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_tag       <= '0;
      r_add_valid <= 1'b0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_tv        <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) r_tid[i] <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_add_valid <= w_hit;
      if (w_hit) begin
        r_add_a <= req_a[w_gnt_idx*W +: W];
        r_add_b <= req_b[w_gnt_idx*W +: W];
        r_tag   <= w_gnt_idx;
        r_ptr   <= (w_gnt_idx == IDW'(N-1)) ? '0 : w_gnt_idx + 1'b1;
      end

      // Tag pipe shifts every cycle, mirroring the datapath stages.
      r_tv[0]  <= r_add_valid;
      r_tid[0] <= r_tag;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_tv[i]  <= r_tv[i-1];
        r_tid[i] <= r_tid[i-1];
      end

      r_rsp_valid <= r_tv[LATENCY-1];
      if (r_tv[LATENCY-1]) begin
        r_rsp_id  <= r_tid[LATENCY-1];
        r_rsp_sum <= add_sum;
      end

      // Built from next-state terms so busy matches the registers it summarises.
      r_busy <= w_hit | r_add_valid | (|r_tv);
    end
  end

  assign req_ready = w_grant;
  assign add_valid = r_add_valid;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign busy      = r_busy;

endmodule
